// File: rtl/matrix_seq.sv
// Matrix-multiply sequencer: walks C = A*B row-major, driving MAC strobes and RAM addresses.
// Optional busy-cycle counter on o_cycles is enabled with `define MATRIX_SEQ_PERF_EN.
module matrix_seq #(
    parameter int DIM_W = 8,
    parameter int ADR_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [DIM_W-1:0] i_rows,
    input  logic [DIM_W-1:0] i_inner,
    input  logic [DIM_W-1:0] i_cols,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic [ADR_W-1:0] o_fm_adr,
    output logic [ADR_W-1:0] o_sm_adr,
    output logic             o_mac_clr,
    output logic             o_mac_en,
    output logic             o_wr_en,
    output logic [ADR_W-1:0] o_t_adr,
    output logic [31:0]      o_cycles
);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_MAC, S_WRITE, S_DONE} state_t;

    localparam int              PW  = 2 * DIM_W;
    localparam longint unsigned LIM = 64'd1 << ADR_W;

    state_t           r_state, w_next;
    logic [DIM_W-1:0] r_rows, r_inner, r_cols;
    logic [DIM_W-1:0] r_r, r_c, r_k;
    logic [ADR_W-1:0] r_fm_base, r_elem;
    logic [ADR_W-1:0] r_fm_adr, r_sm_adr, r_t_adr;
    logic             r_err;

    logic [PW-1:0] w_p_ri, w_p_ic, w_p_rc;
    logic          w_bad, w_last_k, w_last_c, w_last_r;

    // Size check happens only at acceptance, so these products never touch the address path.
    assign w_p_ri = PW'(i_rows)  * PW'(i_inner);
    assign w_p_ic = PW'(i_inner) * PW'(i_cols);
    assign w_p_rc = PW'(i_rows)  * PW'(i_cols);
    assign w_bad  = (i_rows == '0) || (i_inner == '0) || (i_cols == '0) ||
                    (64'(w_p_ri) > LIM) || (64'(w_p_ic) > LIM) || (64'(w_p_rc) > LIM);

    assign w_last_k = (r_k == r_inner - DIM_W'(1));
    assign w_last_c = (r_c == r_cols  - DIM_W'(1));
    assign w_last_r = (r_r == r_rows  - DIM_W'(1));

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        o_busy    = 1'b0;
        o_done    = 1'b0;
        o_err     = 1'b0;
        o_mac_clr = 1'b0;
        o_mac_en  = 1'b0;
        o_wr_en   = 1'b0;
        case (r_state)
            S_IDLE:  if (i_start) w_next = w_bad ? S_DONE : S_CLEAR;
            S_CLEAR: begin
                o_busy    = 1'b1;
                o_mac_clr = 1'b1;
                w_next    = S_MAC;
            end
            S_MAC: begin
                o_busy   = 1'b1;
                o_mac_en = 1'b1;
                if (w_last_k) w_next = S_WRITE;
            end
            S_WRITE: begin
                o_busy  = 1'b1;
                o_wr_en = 1'b1;
                w_next  = (w_last_c && w_last_r) ? S_DONE : S_CLEAR;
            end
            S_DONE: begin
                o_done = 1'b1;
                o_err  = r_err;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Addresses advance by +1 (A) and +cols (B); r_fm_base tracks r*inner, r_elem tracks r*cols+c.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rows    <= '0;
            r_inner   <= '0;
            r_cols    <= '0;
            r_r       <= '0;
            r_c       <= '0;
            r_k       <= '0;
            r_fm_base <= '0;
            r_elem    <= '0;
            r_fm_adr  <= '0;
            r_sm_adr  <= '0;
            r_t_adr   <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_rows    <= i_rows;
                    r_inner   <= i_inner;
                    r_cols    <= i_cols;
                    r_err     <= w_bad;
                    r_r       <= '0;
                    r_c       <= '0;
                    r_k       <= '0;
                    r_fm_base <= '0;
                    r_elem    <= '0;
                end
                S_CLEAR: begin
                    r_k      <= '0;
                    r_fm_adr <= r_fm_base;
                    r_sm_adr <= ADR_W'(r_c);
                end
                S_MAC: begin
                    if (!w_last_k) begin
                        r_k      <= r_k + DIM_W'(1);
                        r_fm_adr <= r_fm_adr + ADR_W'(1);
                        r_sm_adr <= r_sm_adr + ADR_W'(r_cols);
                    end else begin
                        r_t_adr <= r_elem;
                    end
                end
                S_WRITE: begin
                    r_elem <= r_elem + ADR_W'(1);
                    if (w_last_c) begin
                        r_c       <= '0;
                        r_r       <= r_r + DIM_W'(1);
                        r_fm_base <= r_fm_base + ADR_W'(r_inner);
                    end else begin
                        r_c <= r_c + DIM_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_fm_adr = r_fm_adr;
    assign o_sm_adr = r_sm_adr;
    assign o_t_adr  = r_t_adr;

`ifdef MATRIX_SEQ_PERF_EN
    logic [31:0] r_cycles;
    always_ff @(posedge i_clk) begin
        if (i_rst)                            r_cycles <= '0;
        else if (r_state == S_IDLE && i_start) r_cycles <= '0;
        else if (o_busy && r_cycles != '1)     r_cycles <= r_cycles + 32'd1;
    end
    assign o_cycles = r_cycles;
`else
    assign o_cycles = '0;
`endif

endmodule

// File: tb/tb_matrix_seq.sv
// Directed bench for matrix_seq: address streams, timing, error paths, reset abort, start ignore.
module tb_matrix_seq;
    logic       clk = 1'b0;
    logic       rst, start;
    logic [7:0] rows, inner, cols;
    logic       busy, done, err, clr, en, wr;
    logic [7:0] fm, sm, tadr;
    logic [31:0] cycles;

    int pass_n = 0;
    int tot_n  = 0;

    int fm_q[$], sm_q[$], t_q[$];
    int busy_n, clr_n, en_n, wr_n, done_n, err_n, excl_n, done_idx;
    logic [31:0] cyc_at_done;
    bit timed_out;

    matrix_seq #(.DIM_W(8), .ADR_W(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .i_rows(rows), .i_inner(inner), .i_cols(cols),
        .o_busy(busy), .o_done(done), .o_err(err),
        .o_fm_adr(fm), .o_sm_adr(sm),
        .o_mac_clr(clr), .o_mac_en(en), .o_wr_en(wr),
        .o_t_adr(tadr), .o_cycles(cycles)
    );

    always #5 clk = ~clk;

    function automatic int exp_cyc(input int b);
`ifdef MATRIX_SEQ_PERF_EN
        return b;
`else
        return 0;
`endif
    endfunction

    // Pulses start, scrambles the dimension inputs afterwards, and records one sample per cycle.
    task automatic run_op(input int r, input int k, input int c, input int pulse_at, input int max_cyc);
        fm_q.delete(); sm_q.delete(); t_q.delete();
        busy_n = 0; clr_n = 0; en_n = 0; wr_n = 0; done_n = 0; err_n = 0; excl_n = 0;
        done_idx = -1; cyc_at_done = '0; timed_out = 0;
        @(negedge clk);
        rows = 8'(r); inner = 8'(k); cols = 8'(c); start = 1'b1;
        @(negedge clk);
        start = 1'b0; rows = 8'd0; inner = 8'd0; cols = 8'd0;
        for (int n = 0; n < max_cyc; n++) begin
            if (busy) busy_n++;
            if (clr) clr_n++;
            if (en) begin en_n++; fm_q.push_back(int'(fm)); sm_q.push_back(int'(sm)); end
            if (wr) begin wr_n++; t_q.push_back(int'(tadr)); end
            if (int'(clr) + int'(en) + int'(wr) > 1) excl_n++;
            if (done) begin
                done_n++;
                if (err) err_n++;
                if (done_idx < 0) begin done_idx = n; cyc_at_done = cycles; end
            end
            if (done_idx >= 0 && n >= done_idx + 2) break;
            if (n == pulse_at) begin
                start = 1'b1; rows = 8'd3; inner = 8'd1; cols = 8'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (done_idx < 0) timed_out = 1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; rows = 8'd0; inner = 8'd0; cols = 8'd0;
        repeat (3) @(negedge clk);
        tot_n++;
        if ({busy, done, err, clr, en, wr, fm, sm, tadr, cycles} !== '0)
            $display("FAIL reset_outputs: got busy=%b done=%b err=%b clr=%b en=%b wr=%b fm=%0d sm=%0d t=%0d cyc=%0d, need all 0",
                     busy, done, err, clr, en, wr, fm, sm, tadr, cycles);
        else pass_n++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_1x1x1();
        run_op(1, 1, 1, -1, 50);
        tot_n++;
        if (timed_out) $display("FAIL 1x1_timeout: no o_done within 50 cycles"); else pass_n++;
        tot_n++;
        if (busy_n !== 3 || done_idx !== 3)
            $display("FAIL 1x1_latency: busy=%0d done_idx=%0d, need 3/3", busy_n, done_idx);
        else pass_n++;
        tot_n++;
        if (clr_n !== 1 || en_n !== 1 || wr_n !== 1 || fm_q[0] !== 0 || sm_q[0] !== 0 || t_q[0] !== 0)
            $display("FAIL 1x1_strobes: clr=%0d en=%0d wr=%0d, need 1/1/1 at address 0", clr_n, en_n, wr_n);
        else pass_n++;
        tot_n++;
        if (err_n !== 0 || done_n !== 1)
            $display("FAIL 1x1_done: done=%0d err=%0d, need 1/0", done_n, err_n);
        else pass_n++;
        tot_n++;
        if (cyc_at_done !== 32'(exp_cyc(3)))
            $display("FAIL 1x1_cycles: got %0d, need %0d", cyc_at_done, exp_cyc(3));
        else pass_n++;
    endtask

    task automatic test_2x3x2();
        int efm[12] = '{0,1,2, 0,1,2, 3,4,5, 3,4,5};
        int esm[12] = '{0,2,4, 1,3,5, 0,2,4, 1,3,5};
        bit bad;
        run_op(2, 3, 2, -1, 100);
        tot_n++;
        if (timed_out || busy_n !== 20 || done_idx !== 20 || done_n !== 1 || err_n !== 0)
            $display("FAIL 2x3x2_timing: busy=%0d done_idx=%0d dones=%0d errs=%0d, need 20/20/1/0",
                     busy_n, done_idx, done_n, err_n);
        else pass_n++;
        bad = (fm_q.size() != 12) || (sm_q.size() != 12);
        if (!bad) for (int i = 0; i < 12; i++) if (fm_q[i] != efm[i] || sm_q[i] != esm[i]) bad = 1;
        tot_n++;
        if (bad) $display("FAIL 2x3x2_addrs: %0d A/B reads do not match expected sequence", fm_q.size());
        else pass_n++;
        bad = (t_q.size() != 4);
        if (!bad) for (int i = 0; i < 4; i++) if (t_q[i] != i) bad = 1;
        tot_n++;
        if (bad) $display("FAIL 2x3x2_writes: got %0d writes, need t=0,1,2,3", t_q.size());
        else pass_n++;
        tot_n++;
        if (clr_n !== 4 || excl_n !== 0)
            $display("FAIL 2x3x2_clr_excl: clr=%0d overlaps=%0d, need 4/0", clr_n, excl_n);
        else pass_n++;
        tot_n++;
        if (fm !== 8'd5 || sm !== 8'd5 || tadr !== 8'd3)
            $display("FAIL 2x3x2_hold: fm=%0d sm=%0d t=%0d, need 5/5/3", fm, sm, tadr);
        else pass_n++;
        tot_n++;
        if (cyc_at_done !== 32'(exp_cyc(20)))
            $display("FAIL 2x3x2_cycles: got %0d, need %0d", cyc_at_done, exp_cyc(20));
        else pass_n++;
    endtask

    task automatic test_zero_dim();
        run_op(2, 0, 2, -1, 20);
        tot_n++;
        if (timed_out || done_idx !== 0 || err_n !== 1)
            $display("FAIL zero_dim_err: done_idx=%0d errs=%0d, need 0/1", done_idx, err_n);
        else pass_n++;
        tot_n++;
        if (busy_n !== 0 || clr_n + en_n + wr_n !== 0)
            $display("FAIL zero_dim_quiet: busy=%0d strobes=%0d, need 0/0", busy_n, clr_n + en_n + wr_n);
        else pass_n++;
    endtask

    task automatic test_oversize();
        run_op(16, 17, 1, -1, 20);
        tot_n++;
        if (timed_out || done_idx !== 0 || err_n !== 1 || busy_n !== 0 || clr_n + en_n + wr_n !== 0)
            $display("FAIL oversize_err: done_idx=%0d errs=%0d busy=%0d strobes=%0d, need 0/1/0/0",
                     done_idx, err_n, busy_n, clr_n + en_n + wr_n);
        else pass_n++;
        tot_n++;
        if (cyc_at_done !== 32'd0)
            $display("FAIL oversize_cycles: got %0d, need 0", cyc_at_done);
        else pass_n++;
    endtask

    task automatic test_full_size();
        run_op(16, 16, 1, -1, 400);
        tot_n++;
        if (timed_out || err_n !== 0 || busy_n !== 288)
            $display("FAIL full_size_timing: errs=%0d busy=%0d, need 0/288", err_n, busy_n);
        else pass_n++;
        tot_n++;
        if (fm_q.size() != 256 || t_q.size() != 16)
            $display("FAIL full_size_counts: reads=%0d writes=%0d, need 256/16", fm_q.size(), t_q.size());
        else if (fm_q[255] != 255 || sm_q[255] != 15 || t_q[15] != 15)
            $display("FAIL full_size_last: fm=%0d sm=%0d t=%0d, need 255/15/15", fm_q[255], sm_q[255], t_q[15]);
        else pass_n++;
    endtask

    task automatic test_reset_mid();
        int wseen = 0;
        int act = 0;
        bit found = 0;
        bit bad;
        @(negedge clk);
        rows = 8'd2; inner = 8'd2; cols = 8'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (wr) wseen++;
            if (wseen == 1 && en) begin found = 1; break; end
            @(negedge clk);
        end
        tot_n++;
        if (!found) $display("FAIL reset_mid_reach: second element MAC not seen in 50 cycles");
        else pass_n++;
        rst = 1'b1;
        @(negedge clk);
        tot_n++;
        if ({busy, done, err, clr, en, wr, fm, sm, tadr, cycles} !== '0)
            $display("FAIL reset_mid_outputs: busy=%b done=%b clr=%b en=%b wr=%b fm=%0d sm=%0d t=%0d cyc=%0d, need all 0",
                     busy, done, clr, en, wr, fm, sm, tadr, cycles);
        else pass_n++;
        rst = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (wr || done || busy || en || clr) act++;
        end
        tot_n++;
        if (act !== 0) $display("FAIL reset_mid_quiet: %0d active cycles after abort, need 0", act);
        else pass_n++;
        run_op(2, 2, 2, -1, 80);
        bad = timed_out || busy_n != 16 || t_q.size() != 4 || err_n != 0;
        if (!bad) for (int i = 0; i < 4; i++) if (t_q[i] != i) bad = 1;
        if (!bad && fm_q.size() == 8) begin
            if (fm_q[4] != 2 || fm_q[7] != 3 || sm_q[2] != 1 || sm_q[3] != 3) bad = 1;
        end else bad = 1;
        tot_n++;
        if (bad) $display("FAIL reset_mid_rerun: busy=%0d writes=%0d reads=%0d, need 16/4/8 in order",
                          busy_n, t_q.size(), fm_q.size());
        else pass_n++;
    endtask

    task automatic test_restart_ignored();
        bit bad;
        run_op(2, 2, 2, 5, 80);
        bad = (t_q.size() != 4);
        if (!bad) for (int i = 0; i < 4; i++) if (t_q[i] != i) bad = 1;
        tot_n++;
        if (bad || done_n !== 1 || busy_n !== 16 || timed_out)
            $display("FAIL restart_ignored: writes=%0d dones=%0d busy=%0d, need 4/1/16", t_q.size(), done_n, busy_n);
        else pass_n++;
        tot_n++;
        if (cyc_at_done !== 32'(exp_cyc(16)))
            $display("FAIL restart_cycles: got %0d, need %0d", cyc_at_done, exp_cyc(16));
        else pass_n++;
    endtask

    initial begin
        test_reset();
        test_1x1x1();
        test_2x3x2();
        test_zero_dim();
        test_oversize();
        test_full_size();
        test_reset_mid();
        test_restart_ignored();
        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end
endmodule
